// File: rtl/mc_pkg.sv
// Shared definitions for the multicycle MIPS-subset controller:
// state encoding, opcode/funct values, ALU function codes and ALU op classes.
package mc_pkg;

    // One state per cycle; the 4-bit encoding is also what state_o reports.
    typedef enum logic [3:0] {
        S_FETCH   = 4'd0,
        S_DECODE  = 4'd1,
        S_MEMADR  = 4'd2,
        S_MEMRD   = 4'd3,
        S_MEMWB   = 4'd4,
        S_MEMWR   = 4'd5,
        S_RTYPEEX = 4'd6,
        S_RTYPEWB = 4'd7,
        S_BEQEX   = 4'd8,
        S_ADDIEX  = 4'd9,
        S_ADDIWB  = 4'd10,
        S_JEX     = 4'd11
    } state_t;

    // Opcodes (instr[31:26]).
    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_J     = 6'b000010;

    // R-type funct codes (instr[5:0]).
    localparam logic [5:0] FN_ADD = 6'b100000;
    localparam logic [5:0] FN_SUB = 6'b100010;
    localparam logic [5:0] FN_AND = 6'b100100;
    localparam logic [5:0] FN_OR  = 6'b100101;
    localparam logic [5:0] FN_SLT = 6'b101010;

    // ALU function codes driven on alu_control.
    localparam logic [2:0] ALU_AND = 3'b000;
    localparam logic [2:0] ALU_OR  = 3'b001;
    localparam logic [2:0] ALU_ADD = 3'b010;
    localparam logic [2:0] ALU_SUB = 3'b110;
    localparam logic [2:0] ALU_SLT = 3'b111;

    // What the current state wants from the ALU.
    typedef enum logic [1:0] {
        AOP_ADD   = 2'd0,
        AOP_SUB   = 2'd1,
        AOP_FUNCT = 2'd2
    } aluop_t;

    // True for every opcode the controller knows how to sequence.
    function automatic logic op_supported(input logic [5:0] op);
        return (op == OP_RTYPE) || (op == OP_LW) || (op == OP_SW) ||
               (op == OP_BEQ) || (op == OP_ADDI) || (op == OP_J);
    endfunction

endpackage

// File: rtl/mc_ctrl_if.sv
// Controller <-> datapath bundle: instruction fields and zero flag in,
// mux selects, enables, ALU code and debug state out.
interface mc_ctrl_if;
    logic [5:0] op;
    logic [5:0] funct;
    logic       zero;
    logic [2:0] alu_control;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic       iord;
    logic       ir_write;
    logic       mem_write;
    logic       reg_write;
    logic       reg_dst;
    logic       mem_to_reg;
    logic [1:0] pc_src;
    logic       pc_en;
    logic       illegal;
    logic [3:0] state_o;

    // Controller side.
    modport master (
        input  op, funct, zero,
        output alu_control, alu_src_a, alu_src_b, iord, ir_write,
               mem_write, reg_write, reg_dst, mem_to_reg, pc_src,
               pc_en, illegal, state_o
    );

    // Datapath side.
    modport slave (
        output op, funct, zero,
        input  alu_control, alu_src_a, alu_src_b, iord, ir_write,
               mem_write, reg_write, reg_dst, mem_to_reg, pc_src,
               pc_en, illegal, state_o
    );
endinterface

// File: rtl/mc_aludec.sv
// ALU decoder: maps the requested op class (and funct for R-type) to the
// 3-bit ALU function code. bad_funct flags any funct outside the supported
// set regardless of class, so DECODE can check it while the ALU adds.
module mc_aludec
    import mc_pkg::*;
(
    input  aluop_t     aluop,
    input  logic [5:0] funct,
    output logic [2:0] alu_control,
    output logic       bad_funct
);

    logic [2:0] funct_code;

    // Funct lookup; unknown funct falls back to add.
    always_comb begin
        funct_code = ALU_ADD;
        bad_funct  = 1'b0;
        unique case (funct)
            FN_ADD:  funct_code = ALU_ADD;
            FN_SUB:  funct_code = ALU_SUB;
            FN_AND:  funct_code = ALU_AND;
            FN_OR:   funct_code = ALU_OR;
            FN_SLT:  funct_code = ALU_SLT;
            default: bad_funct  = 1'b1;
        endcase
    end

    // Class selection.
    always_comb begin
        alu_control = ALU_ADD;
        unique case (aluop)
            AOP_ADD:   alu_control = ALU_ADD;
            AOP_SUB:   alu_control = ALU_SUB;
            AOP_FUNCT: alu_control = funct_code;
            default:   alu_control = ALU_ADD;
        endcase
    end

endmodule

// File: rtl/mc_ctrl.sv
// Multicycle MIPS-subset controller (lw, sw, R-type, beq, addi, j).
// Moore FSM, one state per cycle; only pc_en in BEQEX looks at zero.
// op/funct are consulted only in DECODE, MEMADR and RTYPEEX.
module mc_ctrl
    import mc_pkg::*;
(
    input  logic      clk,
    input  logic      reset_n,
    mc_ctrl_if.master bus
);

    state_t     state_q, state_d;
    aluop_t     aluop;
    logic       alu_used;
    logic [2:0] alu_code;
    logic       bad_funct;

    logic       src_a;
    logic [1:0] src_b;
    logic       iord;
    logic       ir_write;
    logic       mem_write;
    logic       reg_write;
    logic       reg_dst;
    logic       mem_to_reg;
    logic [1:0] pc_src;
    logic       pc_write;
    logic       branch;
    logic       illegal;

    mc_aludec u_aludec (
        .aluop       (aluop),
        .funct       (bus.funct),
        .alu_control (alu_code),
        .bad_funct   (bad_funct)
    );

    // State register; reset always lands in FETCH.
    always_ff @(posedge clk) begin
        if (!reset_n) state_q <= S_FETCH;
        else          state_q <= state_d;
    end

    // Next state and per-state control decode.
    always_comb begin
        state_d    = state_q;
        aluop      = AOP_ADD;
        alu_used   = 1'b0;
        src_a      = 1'b0;
        src_b      = 2'b00;
        iord       = 1'b0;
        ir_write   = 1'b0;
        mem_write  = 1'b0;
        reg_write  = 1'b0;
        reg_dst    = 1'b0;
        mem_to_reg = 1'b0;
        pc_src     = 2'b00;
        pc_write   = 1'b0;
        branch     = 1'b0;
        illegal    = 1'b0;
        unique case (state_q)
            S_FETCH: begin
                alu_used = 1'b1;
                src_b    = 2'b01;
                ir_write = 1'b1;
                pc_write = 1'b1;
                state_d  = S_DECODE;
            end
            S_DECODE: begin
                // Precompute the branch target while the opcode is decoded.
                alu_used = 1'b1;
                src_b    = 2'b11;
                unique case (bus.op)
                    OP_LW, OP_SW: state_d = S_MEMADR;
                    OP_RTYPE: begin
                        state_d = S_RTYPEEX;
                        illegal = bad_funct;
                    end
                    OP_BEQ:  state_d = S_BEQEX;
                    OP_ADDI: state_d = S_ADDIEX;
                    OP_J:    state_d = S_JEX;
                    default: begin
                        state_d = S_FETCH;
                        illegal = 1'b1;
                    end
                endcase
            end
            S_MEMADR: begin
                alu_used = 1'b1;
                src_a    = 1'b1;
                src_b    = 2'b10;
                if (bus.op == OP_LW)      state_d = S_MEMRD;
                else if (bus.op == OP_SW) state_d = S_MEMWR;
                else                      state_d = S_FETCH;
            end
            S_MEMRD: begin
                iord    = 1'b1;
                state_d = S_MEMWB;
            end
            S_MEMWB: begin
                mem_to_reg = 1'b1;
                reg_write  = 1'b1;
                state_d    = S_FETCH;
            end
            S_MEMWR: begin
                iord      = 1'b1;
                mem_write = 1'b1;
                state_d   = S_FETCH;
            end
            S_RTYPEEX: begin
                alu_used = 1'b1;
                aluop    = AOP_FUNCT;
                src_a    = 1'b1;
                state_d  = S_RTYPEWB;
            end
            S_RTYPEWB: begin
                reg_dst   = 1'b1;
                reg_write = 1'b1;
                state_d   = S_FETCH;
            end
            S_BEQEX: begin
                alu_used = 1'b1;
                aluop    = AOP_SUB;
                src_a    = 1'b1;
                pc_src   = 2'b01;
                branch   = 1'b1;
                state_d  = S_FETCH;
            end
            S_ADDIEX: begin
                alu_used = 1'b1;
                src_a    = 1'b1;
                src_b    = 2'b10;
                state_d  = S_ADDIWB;
            end
            S_ADDIWB: begin
                reg_write = 1'b1;
                state_d   = S_FETCH;
            end
            S_JEX: begin
                pc_src   = 2'b10;
                pc_write = 1'b1;
                state_d  = S_FETCH;
            end
            default: state_d = S_FETCH;
        endcase
    end

    // Output stage: everything held at 0 while reset_n is low.
    always_comb begin
        bus.alu_control = 3'b000;
        bus.alu_src_a   = 1'b0;
        bus.alu_src_b   = 2'b00;
        bus.iord        = 1'b0;
        bus.ir_write    = 1'b0;
        bus.mem_write   = 1'b0;
        bus.reg_write   = 1'b0;
        bus.reg_dst     = 1'b0;
        bus.mem_to_reg  = 1'b0;
        bus.pc_src      = 2'b00;
        bus.pc_en       = 1'b0;
        bus.illegal     = 1'b0;
        bus.state_o     = 4'd0;
        if (reset_n) begin
            bus.alu_control = alu_used ? alu_code : 3'b000;
            bus.alu_src_a   = src_a;
            bus.alu_src_b   = src_b;
            bus.iord        = iord;
            bus.ir_write    = ir_write;
            bus.mem_write   = mem_write;
            bus.reg_write   = reg_write;
            bus.reg_dst     = reg_dst;
            bus.mem_to_reg  = mem_to_reg;
            bus.pc_src      = pc_src;
            bus.pc_en       = pc_write | (branch & bus.zero);
            bus.illegal     = illegal;
            bus.state_o     = state_q;
        end
    end

endmodule

// File: tb/tb_mc_ctrl.sv
// Bench for mc_ctrl: directed instruction sequences, one expected output
// vector per cycle pushed to a queue, compared by an independent monitor.
module tb_mc_ctrl;

    logic clk;
    logic reset_n;

    mc_ctrl_if bus ();

    mc_ctrl dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    // Clock / reset.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Scoreboard state.
    logic [19:0] exp_q[$];
    string       name_q[$];
    int          total = 0;
    int          bad   = 0;

    // Vector layout: state, alu_control, src_a, src_b, iord, ir_write,
    // mem_write, reg_write, reg_dst, mem_to_reg, pc_src, pc_en, illegal.
    function automatic logic [19:0] ev(
        input logic [3:0] st, input logic [2:0] ac, input logic sa,
        input logic [1:0] sb, input logic io, input logic irw,
        input logic mw, input logic rw, input logic rd, input logic m2r,
        input logic [1:0] pcs, input logic pcen, input logic ill);
        return {st, ac, sa, sb, io, irw, mw, rw, rd, m2r, pcs, pcen, ill};
    endfunction

    // Monitor: every cycle, compare the presented outputs with the oldest
    // expected entry.
    always @(negedge clk) begin
        logic [19:0] act;
        logic [19:0] e;
        string       nm;
        if (exp_q.size() != 0) begin
            e  = exp_q.pop_front();
            nm = name_q.pop_front();
            act = {bus.state_o, bus.alu_control, bus.alu_src_a, bus.alu_src_b,
                   bus.iord, bus.ir_write, bus.mem_write, bus.reg_write,
                   bus.reg_dst, bus.mem_to_reg, bus.pc_src, bus.pc_en,
                   bus.illegal};
            total++;
            if (act !== e) begin
                bad++;
                $display("FAIL %s @%0t: got %05h want %05h", nm, $time, act, e);
            end
        end
    end

    // Driver tasks.
    task automatic step(input logic rst, input logic [5:0] o, input logic [5:0] f,
                        input logic z, input logic [19:0] e, input string nm);
        @(posedge clk);
        #1;
        reset_n   = rst;
        bus.op    = o;
        bus.funct = f;
        bus.zero  = z;
        exp_q.push_back(e);
        name_q.push_back(nm);
    endtask

    task automatic fetch(input logic [5:0] o, input logic [5:0] f);
        step(1'b1, o, f, 1'b0,
             ev(4'd0, 3'b010, 1'b0, 2'b01, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b1, 1'b0),
             "fetch");
    endtask

    task automatic decode(input logic [5:0] o, input logic [5:0] f, input logic ill);
        step(1'b1, o, f, 1'b0,
             ev(4'd1, 3'b010, 1'b0, 2'b11, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, ill),
             "decode");
    endtask

    task automatic memadr(input logic [5:0] o);
        step(1'b1, o, 6'd0, 1'b0,
             ev(4'd2, 3'b010, 1'b1, 2'b10, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0),
             "memadr");
    endtask

    task automatic do_lw();
        fetch(6'b100011, 6'd0);
        decode(6'b100011, 6'd0, 1'b0);
        memadr(6'b100011);
        // op scrambled from here on; it must be ignored.
        step(1'b1, 6'b111111, 6'd0, 1'b0,
             ev(4'd3, 3'b000, 1'b0, 2'b00, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0),
             "lw_memrd");
        step(1'b1, 6'b101011, 6'd0, 1'b0,
             ev(4'd4, 3'b000, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 2'b00, 1'b0, 1'b0),
             "lw_memwb");
    endtask

    task automatic do_sw();
        fetch(6'b101011, 6'd0);
        decode(6'b101011, 6'd0, 1'b0);
        memadr(6'b101011);
        step(1'b1, 6'b100011, 6'd0, 1'b0,
             ev(4'd5, 3'b000, 1'b0, 2'b00, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0),
             "sw_memwr");
    endtask

    task automatic do_rtype(input logic [5:0] f, input logic [2:0] ac, input logic ill);
        fetch(6'b000000, f);
        decode(6'b000000, f, ill);
        step(1'b1, 6'b000000, f, 1'b0,
             ev(4'd6, ac, 1'b1, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0),
             "rtype_ex");
        step(1'b1, 6'b100011, 6'b111111, 1'b0,
             ev(4'd7, 3'b000, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 2'b00, 1'b0, 1'b0),
             "rtype_wb");
    endtask

    task automatic do_beq(input logic z);
        fetch(6'b000100, 6'd0);
        decode(6'b000100, 6'd0, 1'b0);
        step(1'b1, 6'b000100, 6'd0, z,
             ev(4'd8, 3'b110, 1'b1, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b01, z, 1'b0),
             "beq_ex");
    endtask

    task automatic do_addi();
        fetch(6'b001000, 6'd0);
        decode(6'b001000, 6'd0, 1'b0);
        step(1'b1, 6'b001000, 6'd0, 1'b0,
             ev(4'd9, 3'b010, 1'b1, 2'b10, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0),
             "addi_ex");
        step(1'b1, 6'b001000, 6'd0, 1'b0,
             ev(4'd10, 3'b000, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0),
             "addi_wb");
    endtask

    task automatic do_j();
        fetch(6'b000010, 6'd0);
        decode(6'b000010, 6'd0, 1'b0);
        step(1'b1, 6'b000010, 6'd0, 1'b1,
             ev(4'd11, 3'b000, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b10, 1'b1, 1'b0),
             "j_ex");
    endtask

    // Stimulus.
    initial begin
        reset_n   = 1'b0;
        bus.op    = 6'd0;
        bus.funct = 6'd0;
        bus.zero  = 1'b0;

        // Two reset cycles: everything 0 (ir_write/pc_en included).
        step(1'b0, 6'b100011, 6'd0, 1'b1, 20'd0, "reset0");
        step(1'b0, 6'b100011, 6'd0, 1'b1, 20'd0, "reset1");

        do_lw();
        do_rtype(6'b101010, 3'b111, 1'b0);
        do_rtype(6'b100010, 3'b110, 1'b0);
        do_rtype(6'b100100, 3'b000, 1'b0);
        do_rtype(6'b100101, 3'b001, 1'b0);
        do_rtype(6'b100000, 3'b010, 1'b0);
        do_rtype(6'b000001, 3'b010, 1'b1);
        do_beq(1'b1);
        do_beq(1'b0);
        do_addi();
        do_j();
        do_sw();

        // Unsupported opcode: DECODE pulses illegal and returns to FETCH.
        fetch(6'b111111, 6'd0);
        decode(6'b111111, 6'd0, 1'b1);

        // sw aborted by reset in MEMWR: no mem_write, FETCH follows.
        fetch(6'b101011, 6'd0);
        decode(6'b101011, 6'd0, 1'b0);
        memadr(6'b101011);
        step(1'b0, 6'b101011, 6'd0, 1'b0, 20'd0, "rst_in_memwr");
        fetch(6'b000010, 6'd0);
        decode(6'b000010, 6'd0, 1'b0);
        step(1'b1, 6'b000010, 6'd0, 1'b0,
             ev(4'd11, 3'b000, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b10, 1'b1, 1'b0),
             "j_after_rst");

        // Let the monitor drain, bounded.
        repeat (3) @(negedge clk);
        total++;
        if (exp_q.size() != 0) begin
            bad++;
            $display("FAIL drain: got %0d pending want 0", exp_q.size());
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
